// File: rtl/sdram_bram_if.sv
// Request/ack port of sdram_top: the initiator drives the master side and
// the responder (controller or BRAM stand-in) drives the slave side.
interface sdram_bram_if;
  logic        sdram_wr_req;
  logic        sdram_rd_req;
  logic        sdram_wr_ack;
  logic        sdram_rd_ack;
  logic [1:0]  sdram_byteenable;
  logic [21:0] sys_wraddr;
  logic [21:0] sys_rdaddr;
  logic [15:0] sys_data_in;
  logic [15:0] sys_data_out;
  logic [8:0]  sdwr_byte;
  logic [8:0]  sdrd_byte;
  logic        sdram_init_done;

  modport master (
    output sdram_wr_req, sdram_rd_req, sdram_byteenable, sys_wraddr, sys_rdaddr,
           sys_data_in, sdwr_byte, sdrd_byte,
    input  sdram_wr_ack, sdram_rd_ack, sys_data_out, sdram_init_done
  );

  modport slave (
    input  sdram_wr_req, sdram_rd_req, sdram_byteenable, sys_wraddr, sys_rdaddr,
           sys_data_in, sdwr_byte, sdrd_byte,
    output sdram_wr_ack, sdram_rd_ack, sys_data_out, sdram_init_done
  );
endinterface

// File: rtl/sdram_bram_responder.sv
// Block-RAM stand-in for sdram_top: single-word writes/reads with
// controller-like ack timing and a power-up init delay.
module sdram_bram_responder #(
  parameter int unsigned AW          = 14,
  parameter int unsigned INIT_CYCLES = 16,
  parameter int unsigned WR_LAT      = 2,
  parameter int unsigned RD_LAT      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  sdram_bram_if.slave  sdram_io
);

  typedef enum logic [2:0] {StInit, StIdle, StWlat, StRlat, StAck, StRelease} state_e;

  state_e        state_q;
  logic [15:0]   cnt_q;
  logic          is_wr_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   wdata_q;
  logic [1:0]    be_q;
  logic          wr_ack_q;
  logic          rd_ack_q;
  logic          init_done_q;
  logic [15:0]   rdata_q;
  logic [15:0]   data_out_q;
  logic          ram_we;

  logic [15:0] mem [2**AW];

  logic unused_inputs;
  assign unused_inputs = ^{sdram_io.sdwr_byte, sdram_io.sdrd_byte,
                           sdram_io.sys_wraddr[21:AW], sdram_io.sys_rdaddr[21:AW]};

  // Gated by rst_n so a reset on the write cycle drops the pending write.
  assign ram_we = rst_n && (state_q == StWlat) && (cnt_q == 16'(WR_LAT - 1));

  always_ff @(posedge clk) begin
    if (ram_we) begin
      if (be_q[0]) mem[addr_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem[addr_q][15:8] <= wdata_q[15:8];
    end
    rdata_q <= mem[addr_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      init_done_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      case (state_q)
        StInit: begin
          if (cnt_q == 16'(INIT_CYCLES - 1)) begin
            init_done_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StIdle: begin
          cnt_q <= '0;
          if (sdram_io.sdram_wr_req) begin
            is_wr_q <= 1'b1;
            addr_q  <= sdram_io.sys_wraddr[AW-1:0];
            wdata_q <= sdram_io.sys_data_in;
            be_q    <= sdram_io.sdram_byteenable;
            state_q <= StWlat;
          end else if (sdram_io.sdram_rd_req) begin
            is_wr_q <= 1'b0;
            addr_q  <= sdram_io.sys_rdaddr[AW-1:0];
            state_q <= StRlat;
          end
        end
        StWlat: begin
          // RAM write happens at cnt == WR_LAT-1; the ack follows one cycle later.
          if (cnt_q == 16'(WR_LAT)) begin
            wr_ack_q <= 1'b1;
            state_q  <= StAck;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StRlat: begin
          if (cnt_q == 16'(RD_LAT - 1)) begin
            data_out_q <= rdata_q;
            rd_ack_q   <= 1'b1;
            state_q    <= StAck;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StAck: state_q <= StRelease;
        StRelease: begin
          if (is_wr_q ? !sdram_io.sdram_wr_req : !sdram_io.sdram_rd_req) state_q <= StIdle;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign sdram_io.sdram_wr_ack    = wr_ack_q;
  assign sdram_io.sdram_rd_ack    = rd_ack_q;
  assign sdram_io.sys_data_out    = data_out_q;
  assign sdram_io.sdram_init_done = init_done_q;

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Bench for sdram_bram_responder: vector table of writes/reads with a read-data
// scoreboard, plus hand-written init, arbitration, hold and reset sequences.
module tb_sdram_bram_responder;
  localparam int unsigned AW          = 14;
  localparam int unsigned INIT_CYCLES = 16;
  localparam int unsigned WR_LAT      = 2;
  localparam int unsigned RD_LAT      = 4;

  logic clk;
  logic rst_n;
  sdram_bram_if sdram_if ();

  sdram_bram_responder #(
    .AW(AW), .INIT_CYCLES(INIT_CYCLES), .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sdram_io (sdram_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [14];
  logic [15:0] sb_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Ack monitor and read-data scoreboard.
  always @(negedge clk) begin
    if (sdram_if.sdram_wr_ack === 1'b1 && sdram_if.sdram_rd_ack === 1'b1) begin
      n_err++;
      $display("FAIL ack_overlap: got both acks high, expected at most one");
    end
    if ((sdram_if.sdram_wr_ack === 1'b1 || sdram_if.sdram_rd_ack === 1'b1) &&
        sdram_if.sdram_init_done !== 1'b1) begin
      n_err++;
      $display("FAIL ack_before_init: got ack with init_done=%b, expected 1",
               sdram_if.sdram_init_done);
    end
    if (sdram_if.sdram_wr_ack === 1'b1) wr_cnt++;
    if (sdram_if.sdram_rd_ack === 1'b1) begin
      rd_cnt++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rd_ack: got rd_ack, expected none pending");
      end else begin
        check("rd_data", 32'(sdram_if.sys_data_out), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic wait_ack(input bit is_wr, input int n0, output int n, output bit got);
    got = 1'b0;
    n   = n0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if ((is_wr ? sdram_if.sdram_wr_ack : sdram_if.sdram_rd_ack) === 1'b1) got = 1'b1;
    end
  endtask

  task automatic do_write(input logic [21:0] addr, input logic [15:0] data,
                          input logic [1:0] be);
    int n;
    bit got;
    @(negedge clk);
    sdram_if.sys_wraddr       = addr;
    sdram_if.sys_data_in      = data;
    sdram_if.sdram_byteenable = be;
    sdram_if.sdram_wr_req     = 1'b1;
    @(negedge clk);
    // Scramble inputs after capture; the transaction must use the captured copy.
    sdram_if.sys_wraddr       = ~addr;
    sdram_if.sys_data_in      = ~data;
    sdram_if.sdram_byteenable = ~be;
    wait_ack(1'b1, 1, n, got);
    check("wr_ack_seen", 32'(got), 32'd1);
    check("wr_latency", 32'(n), 32'(WR_LAT + 2));
    sdram_if.sdram_wr_req = 1'b0;
    @(negedge clk);
    check("wr_ack_pulse", 32'(sdram_if.sdram_wr_ack), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [21:0] addr, input logic [15:0] exp);
    int n;
    bit got;
    @(negedge clk);
    sdram_if.sys_rdaddr   = addr;
    sdram_if.sdram_rd_req = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    sdram_if.sys_rdaddr = ~addr;
    wait_ack(1'b0, 1, n, got);
    check("rd_ack_seen", 32'(got), 32'd1);
    check("rd_latency", 32'(n), 32'(RD_LAT + 1));
    sdram_if.sdram_rd_req = 1'b0;
    @(negedge clk);
    check("rd_ack_pulse", 32'(sdram_if.sdram_rd_ack), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  k;
    int  n;
    bit  got;
    int  w0;
    int  r0;

    vecs[0]  = '{1'b1, 22'h5,      16'h1234, 2'b11, 16'h0};
    vecs[1]  = '{1'b0, 22'h5,      16'h0,    2'b00, 16'h1234};
    vecs[2]  = '{1'b1, 22'h5,      16'hABCD, 2'b10, 16'h0};
    vecs[3]  = '{1'b0, 22'h5,      16'h0,    2'b00, 16'hAB34};
    vecs[4]  = '{1'b1, 22'h5,      16'h00EE, 2'b01, 16'h0};
    vecs[5]  = '{1'b0, 22'h5,      16'h0,    2'b00, 16'hABEE};
    vecs[6]  = '{1'b1, 22'h5,      16'hFFFF, 2'b00, 16'h0};
    vecs[7]  = '{1'b0, 22'h5,      16'h0,    2'b00, 16'hABEE};
    vecs[8]  = '{1'b1, 22'h3FFF,   16'h5555, 2'b11, 16'h0};
    vecs[9]  = '{1'b0, 22'h7FFF,   16'h0,    2'b00, 16'h5555};
    vecs[10] = '{1'b1, 22'h0,      16'h0001, 2'b11, 16'h0};
    vecs[11] = '{1'b0, 22'h3FC000, 16'h0,    2'b00, 16'h0001};
    vecs[12] = '{1'b1, 22'h200,    16'hA5A5, 2'b11, 16'h0};
    vecs[13] = '{1'b0, 22'h200,    16'h0,    2'b00, 16'hA5A5};

    rst_n                     = 1'b0;
    sdram_if.sdram_wr_req     = 1'b0;
    sdram_if.sdram_rd_req     = 1'b0;
    sdram_if.sdram_byteenable = 2'b11;
    sdram_if.sys_wraddr       = '0;
    sdram_if.sys_rdaddr       = '0;
    sdram_if.sys_data_in      = '0;
    sdram_if.sdwr_byte        = 9'd1;
    sdram_if.sdrd_byte        = 9'd1;

    // Reset, then init delay with requests held (must be ignored).
    repeat (3) @(negedge clk);
    check("rst_init_done", 32'(sdram_if.sdram_init_done), 32'd0);
    check("rst_wr_ack", 32'(sdram_if.sdram_wr_ack), 32'd0);
    check("rst_rd_ack", 32'(sdram_if.sdram_rd_ack), 32'd0);
    check("rst_data_out", 32'(sdram_if.sys_data_out), 32'd0);
    rst_n                 = 1'b1;
    sdram_if.sdram_wr_req = 1'b1;
    sdram_if.sdram_rd_req = 1'b1;
    k = 0;
    while (sdram_if.sdram_init_done !== 1'b1 && k < int'(INIT_CYCLES) + 10) begin
      @(negedge clk);
      k++;
    end
    check("init_delay", 32'(k), 32'(INIT_CYCLES));
    sdram_if.sdram_wr_req = 1'b0;
    sdram_if.sdram_rd_req = 1'b0;
    repeat (3) @(negedge clk);
    check("init_no_wr_ack", 32'(wr_cnt), 32'd0);
    check("init_no_rd_ack", 32'(rd_cnt), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].be);
      else               do_read(vecs[i].addr, vecs[i].exp);
    end

    // Simultaneous requests: write first, read only after wr_req drops.
    w0 = wr_cnt;
    r0 = rd_cnt;
    @(negedge clk);
    sdram_if.sys_wraddr       = 22'h9;
    sdram_if.sys_data_in      = 16'h9999;
    sdram_if.sdram_byteenable = 2'b11;
    sdram_if.sys_rdaddr       = 22'h9;
    sdram_if.sdram_wr_req     = 1'b1;
    sdram_if.sdram_rd_req     = 1'b1;
    sb_q.push_back(16'h9999);
    wait_ack(1'b1, 0, n, got);
    check("both_wr_first", 32'(got), 32'd1);
    check("both_wr_latency", 32'(n), 32'(WR_LAT + 2));
    repeat (6) @(negedge clk);
    check("both_rd_blocked", 32'(rd_cnt - r0), 32'd0);
    sdram_if.sdram_wr_req = 1'b0;
    wait_ack(1'b0, 0, n, got);
    check("both_rd_after", 32'(got), 32'd1);
    check("both_rd_latency", 32'(n), 32'(RD_LAT + 2));
    sdram_if.sdram_rd_req = 1'b0;
    repeat (3) @(negedge clk);
    check("both_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("both_rd_count", 32'(rd_cnt - r0), 32'd1);

    // Read request held long after its ack: one transaction only.
    r0 = rd_cnt;
    @(negedge clk);
    sdram_if.sys_rdaddr   = 22'h5;
    sdram_if.sdram_rd_req = 1'b1;
    sb_q.push_back(16'hABEE);
    repeat (20) @(negedge clk);
    sdram_if.sdram_rd_req = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_single_ack", 32'(rd_cnt - r0), 32'd1);

    // Reset in the middle of a read: no ack, outputs cleared, RAM kept.
    do_write(22'h10, 16'h7777, 2'b11);
    do_read(22'h5, 16'hABEE);
    r0 = rd_cnt;
    @(negedge clk);
    sdram_if.sys_rdaddr   = 22'h10;
    sdram_if.sdram_rd_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrd_rd_ack", 32'(sdram_if.sdram_rd_ack), 32'd0);
    check("midrd_data_out", 32'(sdram_if.sys_data_out), 32'd0);
    check("midrd_init_done", 32'(sdram_if.sdram_init_done), 32'd0);
    sdram_if.sdram_rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (sdram_if.sdram_init_done !== 1'b1 && k < int'(INIT_CYCLES) + 10) begin
      @(negedge clk);
      k++;
    end
    check("reinit_delay", 32'(k), 32'(INIT_CYCLES));
    check("midrd_no_ack", 32'(rd_cnt - r0), 32'd0);
    do_read(22'h10, 16'h7777);
    do_read(22'h5, 16'hABEE);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
